// File: rtl/mio_pkg.sv
// Shared constants for the LC-3 memory/IO responder: device-page addresses
// and the transaction FSM encoding.
package mio_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
    localparam logic [6:0]  DEV_PAGE  = 7'h7F;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    function automatic logic is_dev(input logic [15:0] addr);
        return addr[15:9] == DEV_PAGE;
    endfunction

endpackage

// File: rtl/mio_sram.sv
// Single-port synchronous word memory with registered read; contents are
// deliberately left unreset.
module mio_sram #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/mio_responder.sv
// LC-3 memory/IO responder: decodes MIO requests to main memory or the
// keyboard/display/MCR device registers and returns a one-cycle ready.
module mio_responder
    import mio_pkg::*;
#(
    parameter int MEM_AW  = 16,
    parameter int MEM_LAT = 3,
    parameter int DEV_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] a,
    input  logic [15:0] d_in,
    output logic [15:0] mio_out,
    output logic        R,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        kbd_int,
    output logic        mcr_run
);

    localparam int MAX_LAT = (MEM_LAT > DEV_LAT) ? MEM_LAT : DEV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             rw_q, rw_d;
    logic             go_ack, cur_dev;
    logic             dev_rd, dev_wr, mem_we, mem_rd;
    logic             mem_rd_q;
    logic [15:0]      out_q, dev_rdata, sram_rdata;

    logic             rdy_q, rdy_d, ie_q, ie_d, run_q, run_d;
    logic             dv_q, dv_d;
    logic [7:0]       kbuf_q, kbuf_d, dd_q, dd_d;

    // Request fields track the bus only while IDLE; afterwards the latched
    // copy drives the transaction so BUSY-time changes are ignored.
    assign addr_d  = (state_q == IDLE) ? a    : addr_q;
    assign wdata_d = (state_q == IDLE) ? d_in : wdata_q;
    assign rw_d    = (state_q == IDLE) ? R_W  : rw_q;
    assign cur_dev = is_dev(addr_d);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_ack  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MIO_EN) begin
                    if (cur_dev ? (DEV_LAT == 1) : (MEM_LAT == 1)) begin
                        state_d = ACK;
                        go_ack  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = cur_dev ? CNT_W'(DEV_LAT - 1) : CNT_W'(MEM_LAT - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                    go_ack  = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dev_wr = go_ack &  cur_dev &  rw_d;
    assign dev_rd = go_ack &  cur_dev & ~rw_d;
    assign mem_we = go_ack & ~cur_dev &  rw_d;
    assign mem_rd = go_ack & ~cur_dev & ~rw_d;

    mio_sram #(.AW(MEM_AW)) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_d[MEM_AW-1:0]),
        .wdata (wdata_d),
        .rdata (sram_rdata)
    );

    always_comb begin
        dev_rdata = 16'h0000;
        case (addr_d)
            KBSR_ADDR: dev_rdata = {rdy_q, ie_q, 14'b0};
            KBDR_ADDR: dev_rdata = {8'h00, kbuf_q};
            DSR_ADDR:  dev_rdata = {~dv_q, 15'b0};
            DDR_ADDR:  dev_rdata = {8'h00, dd_q};
            MCR_ADDR:  dev_rdata = {run_q, 15'b0};
            default:   dev_rdata = 16'h0000;
        endcase
    end

    // A KBDR read clears rdy; a strobe can only be taken while rdy was 0,
    // so it never competes with a clear that matters.
    always_comb begin
        rdy_d  = rdy_q;
        kbuf_d = kbuf_q;
        ie_d   = ie_q;
        run_d  = run_q;
        dv_d   = dv_q;
        dd_d   = dd_q;
        if (dev_rd && addr_d == KBDR_ADDR) rdy_d = 1'b0;
        if (kbd_valid && !rdy_q) begin
            rdy_d  = 1'b1;
            kbuf_d = kbd_data;
        end
        if (dev_wr && addr_d == KBSR_ADDR) ie_d = wdata_d[14];
        if (dev_wr && addr_d == MCR_ADDR)  run_d = wdata_d[15];
        if (dv_q && disp_ready) dv_d = 1'b0;
        if (dev_wr && addr_d == DDR_ADDR && !dv_q) begin
            dv_d = 1'b1;
            dd_d = wdata_d[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            rw_q     <= 1'b0;
            mem_rd_q <= 1'b0;
            out_q    <= 16'h0000;
            rdy_q    <= 1'b0;
            kbuf_q   <= 8'h00;
            ie_q     <= 1'b0;
            run_q    <= 1'b1;
            dv_q     <= 1'b0;
            dd_q     <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rw_q     <= rw_d;
            mem_rd_q <= mem_rd;
            if (dev_rd) begin
                out_q <= dev_rdata;
            end else if (mem_rd_q) begin
                out_q <= sram_rdata;
            end
            rdy_q    <= rdy_d;
            kbuf_q   <= kbuf_d;
            ie_q     <= ie_d;
            run_q    <= run_d;
            dv_q     <= dv_d;
            dd_q     <= dd_d;
        end
    end

    // Memory read data arrives from the array during ACK and is then kept in out_q.
    assign mio_out    = mem_rd_q ? sram_rdata : out_q;
    assign R          = (state_q == ACK);
    assign kbd_ready  = ~rdy_q;
    assign kbd_int    = rdy_q & ie_q;
    assign mcr_run    = run_q;
    assign disp_valid = dv_q;
    assign disp_data  = dd_q;

endmodule

// File: tb/tb_mio_responder.sv
// Self-checking bench for mio_responder: directed feature tests plus a
// randomized mix checked against a register-level reference model.
module tb_mio_responder;

    logic        clk, reset, MIO_EN, R_W, R;
    logic [15:0] a, d_in, mio_out;
    logic        kbd_valid, kbd_ready, disp_valid, disp_ready, kbd_int, mcr_run;
    logic [7:0]  kbd_data, disp_data;

    int vectors = 0;
    int miscompares = 0;

    mio_responder dut (
        .clk(clk), .reset(reset), .MIO_EN(MIO_EN), .R_W(R_W), .a(a), .d_in(d_in),
        .mio_out(mio_out), .R(R), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
        .kbd_ready(kbd_ready), .disp_valid(disp_valid), .disp_data(disp_data),
        .disp_ready(disp_ready), .kbd_int(kbd_int), .mcr_run(mcr_run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [15:0] mem_m [logic [15:0]];
    logic        m_rdy, m_ie, m_dv, m_run;
    logic [7:0]  m_buf, m_dd;
    logic [15:0] m_out;

    function automatic void model_reset();
        m_rdy = 0; m_ie = 0; m_dv = 0; m_run = 1; m_buf = 0; m_dd = 0; m_out = 0;
    endfunction

    function automatic int exp_lat(input logic [15:0] addr);
        return (addr[15:9] == 7'h7F) ? 1 : 3;
    endfunction

    function automatic void model_access(input logic rw, input logic [15:0] addr, input logic [15:0] wd);
        if (addr[15:9] != 7'h7F) begin
            if (rw) mem_m[addr] = wd;
            else    m_out = mem_m[addr];
        end else begin
            case (addr)
                16'hFE00: if (rw) m_ie = wd[14]; else m_out = {m_rdy, m_ie, 14'b0};
                16'hFE02: if (!rw) begin m_out = {8'h00, m_buf}; m_rdy = 0; end
                16'hFE04: if (!rw) m_out = {~m_dv, 15'b0};
                16'hFE06: begin
                    if (rw) begin
                        if (!m_dv) begin m_dd = wd[7:0]; m_dv = 1; end
                    end else m_out = {8'h00, m_dd};
                end
                16'hFFFE: if (rw) m_run = wd[15]; else m_out = {m_run, 15'b0};
                default:  if (!rw) m_out = 16'h0000;
            endcase
        end
    endfunction

    // Drives one request from posedge+1 and returns the cycle R was seen and mio_out then.
    task automatic txn(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                       output logic [15:0] rd, output int lat);
        MIO_EN = 1; R_W = rw; a = addr; d_in = wd;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (R === 1'b1) begin lat = c; break; end
        end
        rd = mio_out;
        MIO_EN = 0;
        if (lat > 0) begin @(posedge clk); #1; end
        model_access(rw, addr, wd);
    endtask

    task automatic kbd_strobe(input logic [7:0] ch);
        kbd_valid = 1; kbd_data = ch;
        @(posedge clk); #1;
        kbd_valid = 0;
        if (!m_rdy) begin m_buf = ch; m_rdy = 1; end
    endtask

    task automatic disp_drain();
        disp_ready = 1;
        @(posedge clk); #1;
        disp_ready = 0;
        m_dv = 0;
    endtask

    task automatic test_reset();
        vectors++; if (R !== 1'b0) begin miscompares++; $display("FAIL reset_R got %b want 0", R); end
        vectors++; if (mio_out !== 16'h0000) begin miscompares++; $display("FAIL reset_mio_out got %h want 0000", mio_out); end
        vectors++; if (kbd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_kbd_ready got %b want 1", kbd_ready); end
        vectors++; if (kbd_int !== 1'b0) begin miscompares++; $display("FAIL reset_kbd_int got %b want 0", kbd_int); end
        vectors++; if (disp_valid !== 1'b0 || disp_data !== 8'h00) begin miscompares++; $display("FAIL reset_disp got %b/%h want 0/00", disp_valid, disp_data); end
        vectors++; if (mcr_run !== 1'b1) begin miscompares++; $display("FAIL reset_mcr_run got %b want 1", mcr_run); end
        $display("reset: R=%b mio_out=%h mcr_run=%b", R, mio_out, mcr_run);
    endtask

    task automatic test_memory();
        logic [15:0] rd, ad, wd;
        logic rw;
        int lat;
        txn(1, 16'h3000, 16'h1234, rd, lat);
        $display("mem write 3000=1234 lat=%0d", lat);
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL mem_wr_lat got %0d want 3", lat); end
        vectors++; if (rd !== m_out) begin miscompares++; $display("FAIL mem_wr_out got %h want %h", rd, m_out); end
        txn(0, 16'h3000, 16'h0000, rd, lat);
        $display("mem read 3000 -> %h lat=%0d", rd, lat);
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL mem_rd_lat got %0d want 3", lat); end
        vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL mem_rd_data got %h want 1234", rd); end
        vectors++; if (R !== 1'b0) begin miscompares++; $display("FAIL mem_R_one_cycle got %b want 0", R); end
        vectors++; if (mio_out !== 16'h1234) begin miscompares++; $display("FAIL mem_hold got %h want 1234", mio_out); end
        for (int i = 0; i < 16; i++) begin
            ad = 16'h3000 + 16'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            if (!rw && !mem_m.exists(ad)) rw = 1;
            txn(rw, ad, wd, rd, lat);
            $display("mem %s %h data=%h lat=%0d", rw ? "wr" : "rd", ad, rw ? wd : rd, lat);
            vectors++; if (lat != 3) begin miscompares++; $display("FAIL mem_rand_lat got %0d want 3", lat); end
            vectors++; if (rd !== m_out) begin miscompares++; $display("FAIL mem_rand_out addr=%h got %h want %h", ad, rd, m_out); end
        end
    endtask

    task automatic test_mcr();
        logic [15:0] rd;
        int lat;
        txn(0, 16'hFFFE, 16'h0000, rd, lat);
        $display("mcr read -> %h lat=%0d", rd, lat);
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL mcr_rd_lat got %0d want 1", lat); end
        vectors++; if (rd !== 16'h8000) begin miscompares++; $display("FAIL mcr_rd got %h want 8000", rd); end
        txn(1, 16'hFFFE, 16'h0000, rd, lat);
        $display("mcr write 0000 mcr_run=%b", mcr_run);
        vectors++; if (mcr_run !== 1'b0) begin miscompares++; $display("FAIL mcr_wr_run got %b want 0", mcr_run); end
        txn(1, 16'hFFFE, 16'h8000, rd, lat);
        vectors++; if (mcr_run !== 1'b1) begin miscompares++; $display("FAIL mcr_restore got %b want 1", mcr_run); end
    endtask

    task automatic test_keyboard();
        logic [15:0] rd;
        int lat;
        kbd_strobe(8'h41);
        $display("kbd strobe 41 kbd_ready=%b", kbd_ready);
        vectors++; if (kbd_ready !== 1'b0) begin miscompares++; $display("FAIL kbd_ready_after got %b want 0", kbd_ready); end
        kbd_strobe(8'h42);
        txn(0, 16'hFE00, 16'h0000, rd, lat);
        $display("kbsr read -> %h", rd);
        vectors++; if (rd !== 16'h8000) begin miscompares++; $display("FAIL kbsr_rd got %h want 8000", rd); end
        txn(1, 16'hFE00, 16'h4000, rd, lat);
        vectors++; if (kbd_int !== 1'b1) begin miscompares++; $display("FAIL kbd_int_set got %b want 1", kbd_int); end
        txn(0, 16'hFE02, 16'h0000, rd, lat);
        $display("kbdr read -> %h kbd_int=%b kbd_ready=%b", rd, kbd_int, kbd_ready);
        vectors++; if (rd !== 16'h0041) begin miscompares++; $display("FAIL kbdr_rd got %h want 0041", rd); end
        vectors++; if (kbd_int !== 1'b0) begin miscompares++; $display("FAIL kbd_int_clr got %b want 0", kbd_int); end
        vectors++; if (kbd_ready !== 1'b1) begin miscompares++; $display("FAIL kbd_ready_clr got %b want 1", kbd_ready); end
    endtask

    task automatic test_display();
        logic [15:0] rd;
        int lat;
        txn(1, 16'hFE06, 16'h0058, rd, lat);
        $display("ddr write 58 disp_valid=%b disp_data=%h", disp_valid, disp_data);
        vectors++; if (disp_valid !== 1'b1 || disp_data !== 8'h58) begin miscompares++; $display("FAIL ddr_wr got %b/%h want 1/58", disp_valid, disp_data); end
        txn(0, 16'hFE04, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0000) begin miscompares++; $display("FAIL dsr_busy got %h want 0000", rd); end
        txn(1, 16'hFE06, 16'h0059, rd, lat);
        vectors++; if (disp_data !== 8'h58) begin miscompares++; $display("FAIL ddr_drop got %h want 58", disp_data); end
        txn(0, 16'hFE06, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h0058) begin miscompares++; $display("FAIL ddr_rd got %h want 0058", rd); end
        disp_drain();
        $display("display drained disp_valid=%b", disp_valid);
        vectors++; if (disp_valid !== 1'b0) begin miscompares++; $display("FAIL disp_drain got %b want 0", disp_valid); end
        txn(0, 16'hFE04, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h8000) begin miscompares++; $display("FAIL dsr_idle got %h want 8000", rd); end
    endtask

    task automatic test_perturb();
        logic [15:0] rd;
        int lat;
        int rcyc [$];
        txn(1, 16'h3100, 16'hBEEF, rd, lat);
        txn(1, 16'h3101, 16'h5555, rd, lat);
        MIO_EN = 1; R_W = 0; a = 16'h3100; d_in = 16'h0000;
        @(posedge clk); #1;
        MIO_EN = 0; R_W = 1; a = 16'h3101; d_in = 16'hDEAD;
        lat = -1;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk); #1;
            if (R === 1'b1) begin lat = c; break; end
        end
        rd = mio_out;
        $display("perturbed read 3100 -> %h lat=%0d", rd, lat);
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL perturb_lat got %0d want 3", lat); end
        vectors++; if (rd !== 16'hBEEF) begin miscompares++; $display("FAIL perturb_data got %h want BEEF", rd); end
        @(posedge clk); #1;
        model_access(0, 16'h3100, 0);
        txn(0, 16'h3101, 16'h0000, rd, lat);
        vectors++; if (rd !== 16'h5555) begin miscompares++; $display("FAIL perturb_nowrite got %h want 5555", rd); end
        MIO_EN = 1; R_W = 0; a = 16'h3101;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (R === 1'b1) rcyc.push_back(c);
            if (rcyc.size() == 2) break;
        end
        MIO_EN = 0;
        @(posedge clk); #1;
        model_access(0, 16'h3101, 0);
        $display("held request R cycles=%p", rcyc);
        vectors++; if (rcyc.size() != 2) begin miscompares++; $display("FAIL hold_count got %0d want 2", rcyc.size()); end
        else begin
            vectors++; if (rcyc[0] != 3 || rcyc[1] != 7) begin miscompares++; $display("FAIL hold_cycles got %0d,%0d want 3,7", rcyc[0], rcyc[1]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] dev_addrs [0:5] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE, 16'hFE10};
        logic [15:0] rd, ad, wd;
        logic rw;
        int lat, act;
        for (int i = 0; i < 40; i++) begin
            act = $urandom_range(0, 7);
            if (act == 0) begin
                kbd_strobe(8'($urandom));
                $display("rand kbd strobe rdy=%b buf=%h", m_rdy, m_buf);
            end else if (act == 1) begin
                disp_drain();
                $display("rand disp drain");
            end else begin
                ad = (act == 7) ? 16'h3000 + 16'($urandom_range(0, 7)) : dev_addrs[$urandom_range(0, 5)];
                rw = 1'($urandom_range(0, 1));
                wd = 16'($urandom);
                if (!rw && ad[15:9] != 7'h7F && !mem_m.exists(ad)) rw = 1;
                txn(rw, ad, wd, rd, lat);
                $display("rand %s %h data=%h lat=%0d", rw ? "wr" : "rd", ad, rw ? wd : rd, lat);
                vectors++; if (lat != exp_lat(ad)) begin miscompares++; $display("FAIL rand_lat addr=%h got %0d want %0d", ad, lat, exp_lat(ad)); end
                vectors++; if (rd !== m_out) begin miscompares++; $display("FAIL rand_out addr=%h got %h want %h", ad, rd, m_out); end
            end
            vectors++; if (kbd_ready !== ~m_rdy || kbd_int !== (m_rdy & m_ie)) begin miscompares++; $display("FAIL rand_kbd got ready=%b int=%b want %b/%b", kbd_ready, kbd_int, ~m_rdy, m_rdy & m_ie); end
            vectors++; if (disp_valid !== m_dv || disp_data !== m_dd) begin miscompares++; $display("FAIL rand_disp got %b/%h want %b/%h", disp_valid, disp_data, m_dv, m_dd); end
            vectors++; if (mcr_run !== m_run) begin miscompares++; $display("FAIL rand_run got %b want %b", mcr_run, m_run); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        int lat;
        txn(1, 16'h4000, 16'hA5A5, rd, lat);
        txn(0, 16'h4000, 16'h0000, rd, lat);
        kbd_strobe(8'h55);
        txn(1, 16'hFE00, 16'h4000, rd, lat);
        txn(1, 16'hFFFE, 16'h0000, rd, lat);
        MIO_EN = 1; R_W = 1; a = 16'h4000; d_in = 16'h1111;
        @(posedge clk); #3;
        reset = 0;
        #1;
        $display("mid-busy reset R=%b mio_out=%h mcr_run=%b kbd_int=%b", R, mio_out, mcr_run, kbd_int);
        vectors++; if (R !== 1'b0) begin miscompares++; $display("FAIL rst_mid_R got %b want 0", R); end
        vectors++; if (mio_out !== 16'h0000) begin miscompares++; $display("FAIL rst_mid_out got %h want 0000", mio_out); end
        vectors++; if (mcr_run !== 1'b1) begin miscompares++; $display("FAIL rst_mid_run got %b want 1", mcr_run); end
        vectors++; if (kbd_int !== 1'b0) begin miscompares++; $display("FAIL rst_mid_int got %b want 0", kbd_int); end
        MIO_EN = 0;
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        model_reset();
        txn(0, 16'h4000, 16'h0000, rd, lat);
        $display("post-reset read 4000 -> %h lat=%0d", rd, lat);
        vectors++; if (rd !== 16'hA5A5) begin miscompares++; $display("FAIL rst_mem_kept got %h want A5A5", rd); end
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL rst_mem_lat got %0d want 3", lat); end
    endtask

    initial begin
        reset = 0; MIO_EN = 0; R_W = 0; a = 0; d_in = 0;
        kbd_valid = 0; kbd_data = 0; disp_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 reset = 1;
        @(posedge clk); #1;
        test_reset();
        test_memory();
        test_mcr();
        test_keyboard();
        test_display();
        test_perturb();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
